// File: rtl/lamp_sqrt_iter_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : lamp_sqrt_iter_unit_if
//  Purpose  : Operand/result handshake bundle for lamp_sqrt_iter_unit.
//             Upstream side: valid_i/ready_o plus operand fields.
//             Downstream side: valid_o/ready_i plus the result word.
//  Ports    : (interface signals)
//             valid_i, s_i[MANT_W], is_exp_odd_i, inv_i, special_case_i
//             ready_o, valid_o, res_o[RES_W], ready_i
//  Modports : slave  - the square-root unit
//             master - the environment driving operands / taking results
//  Revision : 1.0 - initial release
// ============================================================================
interface lamp_sqrt_iter_unit_if #(
    parameter int MANT_W = 8,
    parameter int RES_W  = 16
);
    logic              valid_i;
    logic              ready_o;
    logic [MANT_W-1:0] s_i;
    logic              is_exp_odd_i;
    logic              inv_i;
    logic              special_case_i;
    logic              valid_o;
    logic              ready_i;
    logic [RES_W-1:0]  res_o;

    modport slave (
        input  valid_i, s_i, is_exp_odd_i, inv_i, special_case_i, ready_i,
        output ready_o, valid_o, res_o
    );

    modport master (
        output valid_i, s_i, is_exp_odd_i, inv_i, special_case_i, ready_i,
        input  ready_o, valid_o, res_o
    );
endinterface
`default_nettype wire

// File: rtl/lamp_sqrt_iter_unit.sv
`default_nettype none
// ============================================================================
//  Module   : lamp_sqrt_iter_unit
//  Purpose  : Iterative mantissa square-root / inverse-square-root engine.
//             Radix-2 restoring square root (one root bit per cycle), then an
//             optional restoring division 2^(2*(RES_W-1)) / root (one quotient
//             bit per cycle) for 1/sqrt. Results are truncated, fixed point
//             1.(RES_W-1).
//  Ports    : clk  - clock, rising edge
//             rst  - asynchronous reset, active low
//             bus  - lamp_sqrt_iter_unit_if.slave (operand + result handshake)
//  Params   : MANT_W - mantissa width incl. hidden bit
//             RES_W  - result width, 2*(RES_W-1) >= MANT_W-1, RES_W >= 2
//             INV_EN - 1: inverse mode built in; 0: inv_i ignored, no divider
//  Revision : 1.0 - initial release
// ============================================================================
module lamp_sqrt_iter_unit #(
    parameter int MANT_W = 8,
    parameter int RES_W  = 16,
    parameter int INV_EN = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    lamp_sqrt_iter_unit_if.slave  bus
);

    localparam int N_W   = 2 * RES_W;
    // Left shift that aligns the 1.(MANT_W-1) radicand to 2*(RES_W-1) fraction bits.
    localparam int SHIFT = 2 * (RES_W - 1) - (MANT_W - 1);
    localparam int CNT_W = (RES_W > 1) ? $clog2(RES_W) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RES_W - 1);
    // Division starts from the dividend 2^(2*RES_W-2) with its low RES_W
    // (all-zero) bits still to be shifted in: partial remainder 2^(RES_W-2).
    localparam logic [RES_W+1:0] DIV_REM_INIT = {{(RES_W+1){1'b0}}, 1'b1} << (RES_W - 2);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SQRT = 3'd1,
        DIV  = 3'd2,
        FIN  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [N_W-1:0]     rad;        // radicand, consumed two bits per cycle from the top
    logic [RES_W+1:0]   rem;        // partial remainder (shared by root and division)
    logic [RES_W-1:0]   root;
    logic [RES_W-1:0]   quo;
    logic               inv_mode;
    logic               special;
    logic               ready_reg;
    logic               valid_reg;
    logic [RES_W-1:0]   res_reg;

    logic [MANT_W:0]    x_in;
    logic [N_W-1:0]     x_ext;

    // Odd exponent doubles the radicand so the result exponent is exact.
    assign x_in  = bus.is_exp_odd_i ? {bus.s_i, 1'b0} : {1'b0, bus.s_i};
    assign x_ext = N_W'(x_in);

    // ------------------------------------------------------------------
    // Square-root step. With k root bits known, rem <= 2*root < 2^RES_W,
    // so only the low RES_W remainder bits feed the next trial and the
    // shifted remainder fits in RES_W+2 bits.
    // ------------------------------------------------------------------
    logic [RES_W+1:0]   sq_acc;
    logic [RES_W+1:0]   sq_trial;
    logic [RES_W+1:0]   sq_diff;
    logic               sq_ge;
    logic [RES_W+1:0]   sq_rem_next;

    always_comb begin
        sq_acc      = {rem[RES_W-1:0], rad[N_W-1 -: 2]};
        sq_trial    = {root, 2'b01};
        sq_diff     = sq_acc - sq_trial;
        sq_ge       = (sq_acc >= sq_trial);
        sq_rem_next = sq_ge ? sq_diff : sq_acc;
    end

    // ------------------------------------------------------------------
    // Division step: remainder stays below the divisor (< 2^RES_W). A zero
    // divisor yields an all-ones quotient, which is the intended result.
    // ------------------------------------------------------------------
    logic               div_ge;
    logic [RES_W+1:0]   div_rem_next;

    generate
        if (INV_EN != 0) begin : g_div
            logic [RES_W+1:0] div_acc;
            logic [RES_W+1:0] div_dvs;
            logic [RES_W+1:0] div_diff;

            always_comb begin
                div_acc      = {1'b0, rem[RES_W-1:0], 1'b0};
                div_dvs      = {2'b00, root};
                div_diff     = div_acc - div_dvs;
                div_ge       = (div_acc >= div_dvs);
                div_rem_next = div_ge ? div_diff : div_acc;
            end
        end else begin : g_no_div
            assign div_ge       = 1'b0;
            assign div_rem_next = '0;
        end
    endgenerate

    // Top remainder bits only hold the final (discarded) remainder.
    logic unused_rem_top;
    assign unused_rem_top = ^rem[RES_W+1:RES_W];

    // ------------------------------------------------------------------
    // Control FSM. FIN is the output-load stage: the result register and
    // valid_o are updated only on the FIN -> DONE edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rad       <= '0;
            rem       <= '0;
            root      <= '0;
            quo       <= '0;
            inv_mode  <= 1'b0;
            special   <= 1'b0;
            ready_reg <= 1'b1;
            valid_reg <= 1'b0;
            res_reg   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.valid_i) begin
                        rad       <= x_ext << SHIFT;
                        rem       <= '0;
                        root      <= '0;
                        quo       <= '0;
                        cnt       <= CNT_LAST;
                        inv_mode  <= bus.inv_i && (INV_EN != 0);
                        special   <= bus.special_case_i;
                        ready_reg <= 1'b0;
                        state     <= bus.special_case_i ? FIN : SQRT;
                    end
                end
                SQRT: begin
                    rad  <= rad << 2;
                    rem  <= sq_rem_next;
                    root <= {root[RES_W-2:0], sq_ge};
                    if (cnt == '0) begin
                        if (inv_mode) begin
                            state <= DIV;
                            cnt   <= CNT_LAST;
                            rem   <= DIV_REM_INIT;
                        end else begin
                            state <= FIN;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DIV: begin
                    rem <= div_rem_next;
                    quo <= {quo[RES_W-2:0], div_ge};
                    if (cnt == '0) begin
                        state <= FIN;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                FIN: begin
                    valid_reg <= 1'b1;
                    res_reg   <= special ? '0 : (inv_mode ? quo : root);
                    state     <= DONE;
                end
                DONE: begin
                    if (bus.ready_i) begin
                        valid_reg <= 1'b0;
                        ready_reg <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready_o = ready_reg;
    assign bus.valid_o = valid_reg;
    assign bus.res_o   = res_reg;

endmodule
`default_nettype wire

// File: tb/tb_lamp_sqrt_iter_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lamp_sqrt_iter_unit
//  Purpose  : Self-checking bench for lamp_sqrt_iter_unit (MANT_W=8, RES_W=16).
//             Reference results come from integer square root / division
//             on the scaled radicand.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lamp_sqrt_iter_unit;

    localparam int MANT_W = 8;
    localparam int RES_W  = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lamp_sqrt_iter_unit_if #(.MANT_W(MANT_W), .RES_W(RES_W)) bus0 ();
    lamp_sqrt_iter_unit_if #(.MANT_W(MANT_W), .RES_W(RES_W)) bus1 ();

    lamp_sqrt_iter_unit #(.MANT_W(MANT_W), .RES_W(RES_W), .INV_EN(1)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    lamp_sqrt_iter_unit #(.MANT_W(MANT_W), .RES_W(RES_W), .INV_EN(0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int      n_cmp  = 0;
    int      n_fail = 0;
    longint  cyc    = 0;
    bit      rand_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // floor(sqrt(N)) and floor(2^30 / floor(sqrt(N))) with plain arithmetic
    function automatic logic [15:0] model(input logic [7:0] s, input bit odd,
                                          input bit inv, input bit sp);
        longint unsigned n;
        longint unsigned q;
        if (sp) return 16'h0000;
        n = longint'(s) * (odd ? 2 : 1);
        n = n << (2 * (RES_W - 1) - (MANT_W - 1));
        q = longint'($sqrt(real'(n)));
        while (q * q > n) q--;
        while ((q + 1) * (q + 1) <= n) q++;
        if (!inv) return q[15:0];
        if (q == 0) return 16'hFFFF;
        n = (64'd1 << (2 * (RES_W - 1))) / q;
        return n[15:0];
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard monitor for dut0, sampled on the falling edge.
    // Latency is counted from the falling edge where the handshake is seen,
    // i.e. one more than the edge-to-valid latency.
    // ------------------------------------------------------------------
    typedef struct {
        logic [15:0] res;
        int          lat;
    } exp_t;

    exp_t    sb[$];
    exp_t    e;
    bit      prev_valid = 1'b0;
    bit      in_flight  = 1'b0;
    longint  acc_cyc    = 0;

    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
            in_flight  = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (bus0.valid_o && !prev_valid) begin
                if (sb.size() == 0) check("spurious_valid", 32'(bus0.valid_o), 32'd0);
                else check("latency", 32'(cyc - acc_cyc), 32'(sb[0].lat));
            end
            if (bus0.valid_o && sb.size() != 0) check("res", 32'(bus0.res_o), 32'(sb[0].res));
            if (in_flight && !bus0.valid_o) check("busy_ready", 32'(bus0.ready_o), 32'd0);
            if (bus0.valid_o && bus0.ready_i) begin
                if (sb.size() != 0) void'(sb.pop_front());
                in_flight = 1'b0;
            end
            if (bus0.valid_i && bus0.ready_o) begin
                e.res = model(bus0.s_i, bus0.is_exp_odd_i, bus0.inv_i, bus0.special_case_i);
                e.lat = bus0.special_case_i ? 2 : (bus0.inv_i ? 2 * RES_W + 2 : RES_W + 2);
                sb.push_back(e);
                acc_cyc   = cyc;
                in_flight = 1'b1;
            end
            prev_valid = bus0.valid_o;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 bus0.ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    // Drive one operand on dut0 until it is accepted (call 1 after a rising edge).
    task automatic send(input logic [7:0] s, input bit odd, input bit inv, input bit sp);
        bit acc;
        acc = 1'b0;
        bus0.s_i            = s;
        bus0.is_exp_odd_i   = odd;
        bus0.inv_i          = inv;
        bus0.special_case_i = sp;
        bus0.valid_i        = 1'b1;
        for (int i = 0; i < 300 && !acc; i++) begin
            @(negedge clk);
            acc = bus0.ready_o;
            @(posedge clk);
            #1;
        end
        bus0.valid_i = 1'b0;
        if (!acc) check("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic wait_valid(output bit got);
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = bus0.valid_o;
        end
    endtask

    task automatic wait_result(input string name, input logic [15:0] exp);
        bit got;
        wait_valid(got);
        check({name, "_valid"}, 32'(got), 32'd1);
        if (got) check(name, 32'(bus0.res_o), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    // dut1 (no inverse hardware): inverse request must give the plain root at 17.
    task automatic send1_check(input string name, input logic [7:0] s, input bit odd,
                               input logic [15:0] exp);
        int lat;
        lat = -1;
        bus1.s_i            = s;
        bus1.is_exp_odd_i   = odd;
        bus1.inv_i          = 1'b1;
        bus1.special_case_i = 1'b0;
        bus1.valid_i        = 1'b1;
        @(negedge clk);
        check({name, "_ready"}, 32'(bus1.ready_o), 32'd1);
        @(posedge clk);
        #1;
        bus1.valid_i = 1'b0;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (bus1.valid_o) begin
                lat = j;
                break;
            end
        end
        check({name, "_latency"}, 32'(lat), 32'd17);
        check(name, 32'(bus1.res_o), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] rs;
        bit         rodd, rinv, rsp;
        bit         got;
        logic [15:0] bp_exp;
        bit         drained;

        bus0.valid_i = 1'b0; bus0.s_i = '0; bus0.is_exp_odd_i = 1'b0;
        bus0.inv_i = 1'b0; bus0.special_case_i = 1'b0; bus0.ready_i = 1'b1;
        bus1.valid_i = 1'b0; bus1.s_i = '0; bus1.is_exp_odd_i = 1'b0;
        bus1.inv_i = 1'b0; bus1.special_case_i = 1'b0; bus1.ready_i = 1'b1;

        // Model anchors
        check("model_80_even_sqrt", 32'(model(8'h80, 1'b0, 1'b0, 1'b0)), 32'h8000);
        check("model_80_even_inv",  32'(model(8'h80, 1'b0, 1'b1, 1'b0)), 32'h8000);
        check("model_80_odd_sqrt",  32'(model(8'h80, 1'b1, 1'b0, 1'b0)), 32'hB504);
        check("model_80_odd_inv",   32'(model(8'h80, 1'b1, 1'b1, 1'b0)), 32'h5A82);
        check("model_F8_even_sqrt", 32'(model(8'hF8, 1'b0, 1'b0, 1'b0)), 32'hB22B);
        check("model_F8_even_inv",  32'(model(8'hF8, 1'b0, 1'b1, 1'b0)), 32'h5BF5);

        // Reset state
        #12;
        check("rst_ready", 32'(bus0.ready_o), 32'd1);
        check("rst_valid", 32'(bus0.valid_o), 32'd0);
        check("rst_res",   32'(bus0.res_o),   32'd0);
        check("rst_ready_noinv", 32'(bus1.ready_o), 32'd1);
        #5 rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed operands
        send(8'h80, 1'b0, 1'b0, 1'b0); wait_result("sqrt_80_even", 16'h8000);
        send(8'h80, 1'b0, 1'b1, 1'b0); wait_result("inv_80_even",  16'h8000);
        send(8'h80, 1'b1, 1'b0, 1'b0); wait_result("sqrt_80_odd",  16'hB504);
        send(8'h80, 1'b1, 1'b1, 1'b0); wait_result("inv_80_odd",   16'h5A82);
        send(8'hF8, 1'b0, 1'b0, 1'b0); wait_result("sqrt_F8_even", 16'hB22B);
        send(8'hF8, 1'b0, 1'b1, 1'b0); wait_result("inv_F8_even",  16'h5BF5);
        send(8'hF8, 1'b1, 1'b1, 1'b1); wait_result("special",      16'h0000);
        send(8'h00, 1'b0, 1'b0, 1'b0); wait_result("zero_sqrt",    16'h0000);
        send(8'h00, 1'b0, 1'b1, 1'b0); wait_result("zero_inv",     16'hFFFF);

        // Build without inverse hardware
        send1_check("noinv_F8", 8'hF8, 1'b0, 16'hB22B);
        send1_check("noinv_80_odd", 8'h80, 1'b1, 16'hB504);

        // Backpressure: hold DONE for 10 cycles, valid_i pulses must be ignored
        bus0.ready_i = 1'b0;
        send(8'hF8, 1'b1, 1'b0, 1'b0);
        bp_exp = model(8'hF8, 1'b1, 1'b0, 1'b0);
        wait_valid(got);
        check("bp_first_valid", 32'(got), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            bus0.valid_i = i[0];
            bus0.s_i     = 8'($urandom);
            bus0.inv_i   = 1'b1;
            @(negedge clk);
            check("bp_valid", 32'(bus0.valid_o), 32'd1);
            check("bp_res",   32'(bus0.res_o),   32'(bp_exp));
        end
        @(posedge clk);
        #1;
        bus0.valid_i = 1'b0;
        bus0.ready_i = 1'b1;
        @(posedge clk);
        #1;
        send(8'hC3, 1'b0, 1'b1, 1'b0); wait_result("after_bp", model(8'hC3, 1'b0, 1'b1, 1'b0));

        // Reset in the middle of a square root
        send(8'hF8, 1'b0, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("midrst_valid", 32'(bus0.valid_o), 32'd0);
        check("midrst_res",   32'(bus0.res_o),   32'd0);
        check("midrst_ready", 32'(bus0.ready_o), 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_valid", 32'(bus0.valid_o), 32'd0);
        send(8'hF8, 1'b0, 1'b0, 1'b0); wait_result("after_rst", 16'hB22B);

        // Random back-to-back traffic with random downstream backpressure
        rand_ready = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            rs   = {1'b1, 7'($urandom)};
            if ($urandom_range(0, 31) == 0) rs = 8'h00;
            rodd = 1'($urandom);
            rinv = 1'($urandom);
            rsp  = ($urandom_range(0, 15) == 0);
            send(rs, rodd, rinv, rsp);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2 bus0.ready_i = 1'b1;
        drained = 1'b0;
        for (int i = 0; i < 300 && !drained; i++) begin
            @(negedge clk);
            drained = (sb.size() == 0) && bus0.ready_o;
        end
        check("drain", 32'(drained), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
